// File: rtl/memShare_config_pkg.sv
// Shared memShare configuration: DRC indices, allocation limits and the
// request/allocation bundles exchanged around the SCU.memShare() scheduler.
package memShare_config_pkg;

    localparam int MEMSHARE_DRC_NUM       = 3;
    localparam int MAX_ALLOC_SEQ_NUM      = 2;
    localparam int ARR_RQST_TRACK_DEPTH   = 4;
    localparam int MEMSHARE_GROUP_SIZE    = 5;
    localparam int MEMSHARE_ADDR_BITWIDTH = 2;

    typedef enum int {
        DRC1_IDX = 0,
        DRC2_IDX = 1,
        DRC3_IDX = 2
    } memShare_drc_index;

    typedef enum logic {
        GP1 = 1'b0,
        GP2 = 1'b1
    } colBank_addr_gropu_e;

    typedef struct packed {
        logic                bank;
        colBank_addr_gropu_e group;
    } colbank_addr_t;

    typedef struct packed {
        logic [MEMSHARE_GROUP_SIZE-1:0]                        mask;
        logic [MEMSHARE_GROUP_SIZE*MEMSHARE_ADDR_BITWIDTH-1:0] addr;
    } memshare_rqst_t;

    typedef struct packed {
        logic [MEMSHARE_GROUP_SIZE-1:0] seq_sel;
        logic                           seq_num;
        logic [MEMSHARE_GROUP_SIZE-1:0] mask;
        logic [MEMSHARE_DRC_NUM-1:0]    drc;
    } memshare_alloc_t;

    function automatic colbank_addr_t colbank_addr_dec(input logic [1:0] addr);
        colbank_addr_t dec;
        dec.group = colBank_addr_gropu_e'(addr[0]);
        dec.bank  = addr[1];
        return dec;
    endfunction

endpackage

// File: rtl/memshare_rqst_profiler_drc_eval.sv
// Combinational sequence split and design-rule checks on one request pattern.
module memshare_drc_eval
    import memShare_config_pkg::*;
#(
    parameter int                          SHARE_GROUP_SIZE   = MEMSHARE_GROUP_SIZE,
    parameter int                          RQST_ADDR_BITWIDTH = MEMSHARE_ADDR_BITWIDTH,
    parameter logic [SHARE_GROUP_SIZE-1:0] SHARE_COL_CONFIG   = 5'b10101
) (
    input  logic [SHARE_GROUP_SIZE-1:0]                    i_mask,
    input  logic [SHARE_GROUP_SIZE*RQST_ADDR_BITWIDTH-1:0] i_addr,
    output logic [SHARE_GROUP_SIZE-1:0]                    o_seq_sel,
    output logic                                           o_seq_num,
    output logic [MEMSHARE_DRC_NUM-1:0]                    o_drc
);

    logic [3:0]    w_used0;
    logic [3:0]    w_used1;
    logic [3:0]    w_shared;
    colbank_addr_t w_dec;

    // Requestors are scanned in index order; the decoded {bank,group} pair is the collision key.
    always_comb begin
        w_used0   = '0;
        w_used1   = '0;
        w_shared  = '0;
        w_dec     = '0;
        o_seq_sel = '0;
        o_drc     = '0;
        for (int i = 0; i < SHARE_GROUP_SIZE; i++) begin
            w_dec = colbank_addr_dec(i_addr[i*RQST_ADDR_BITWIDTH +: 2]);
            if (i_mask[i]) begin
                if (!w_used0[w_dec]) begin
                    w_used0[w_dec] = 1'b1;
                end else begin
                    o_seq_sel[i] = 1'b1;
                    if (!w_used1[w_dec]) begin
                        w_used1[w_dec] = 1'b1;
                    end else begin
                        o_drc[DRC3_IDX] = 1'b1;
                    end
                end
                if (SHARE_COL_CONFIG[i]) begin
                    if (w_shared[w_dec]) begin
                        o_drc[DRC1_IDX] = 1'b1;
                    end
                    w_shared[w_dec] = 1'b1;
                end else if (w_dec.group == GP2) begin
                    o_drc[DRC2_IDX] = 1'b1;
                end
            end
        end
        o_seq_num = |o_seq_sel;
    end

endmodule

// File: rtl/memshare_rqst_profiler.sv
// Arrival-request profiler: buffers share-group request patterns and emits
// a registered allocation word with DRC flags to the memShare scheduler.
module memshare_rqst_profiler
    import memShare_config_pkg::*;
#(
    parameter int                          SHARE_GROUP_SIZE   = MEMSHARE_GROUP_SIZE,
    parameter int                          RQST_ADDR_BITWIDTH = MEMSHARE_ADDR_BITWIDTH,
    parameter logic [SHARE_GROUP_SIZE-1:0] SHARE_COL_CONFIG   = 5'b10101,
    parameter int                          TRACK_DEPTH        = ARR_RQST_TRACK_DEPTH
) (
    input  logic                                           sys_clk,
    input  logic                                           rst,
    input  logic                                           rqst_valid,
    output logic                                           rqst_ready,
    input  logic [SHARE_GROUP_SIZE-1:0]                    rqst_mask,
    input  logic [SHARE_GROUP_SIZE*RQST_ADDR_BITWIDTH-1:0] rqst_addr,
    output logic                                           alloc_valid,
    input  logic                                           alloc_ready,
    output logic [SHARE_GROUP_SIZE-1:0]                    alloc_seq_sel,
    output logic                                           alloc_seq_num,
    output logic [SHARE_GROUP_SIZE-1:0]                    alloc_mask,
    output logic [MEMSHARE_DRC_NUM-1:0]                    drc_flag,
    output logic [$clog2(TRACK_DEPTH):0]                   occupancy,
    output logic [15:0]                                    drc1_cnt
);

    localparam int            PW       = $clog2(TRACK_DEPTH);
    localparam logic [PW:0]   FULL_CNT = (PW+1)'(TRACK_DEPTH);

    memshare_rqst_t  r_mem [TRACK_DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [PW:0]     r_count;
    memshare_alloc_t r_alloc;
    logic            r_alloc_valid;
    logic [15:0]     r_drc1_cnt;

    memshare_rqst_t                w_head;
    memshare_alloc_t               w_head_alloc;
    logic [SHARE_GROUP_SIZE-1:0]   w_seq_sel;
    logic                          w_seq_num;
    logic [MEMSHARE_DRC_NUM-1:0]   w_drc;
    logic                          w_full;
    logic                          w_empty;
    logic                          w_push;
    logic                          w_pop;

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);
    assign w_push  = rqst_valid && !w_full;
    assign w_pop   = !w_empty && (!r_alloc_valid || alloc_ready);
    assign w_head  = r_mem[r_rd_ptr];

    memshare_drc_eval #(
        .SHARE_GROUP_SIZE   (SHARE_GROUP_SIZE),
        .RQST_ADDR_BITWIDTH (RQST_ADDR_BITWIDTH),
        .SHARE_COL_CONFIG   (SHARE_COL_CONFIG)
    ) u_drc_eval (
        .i_mask    (w_head.mask),
        .i_addr    (w_head.addr),
        .o_seq_sel (w_seq_sel),
        .o_seq_num (w_seq_num),
        .o_drc     (w_drc)
    );

    assign w_head_alloc = '{
        seq_sel: w_seq_sel,
        seq_num: w_seq_num,
        mask:    w_head.mask,
        drc:     w_drc
    };

    // Storage is not reset; clearing the pointers discards whatever it holds.
    always_ff @(posedge sys_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= '{mask: rqst_mask, addr: rqst_addr};
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_alloc_valid <= 1'b0;
            r_alloc       <= '0;
            r_drc1_cnt    <= '0;
        end else if (w_pop) begin
            r_alloc_valid <= 1'b1;
            r_alloc       <= w_head_alloc;
            if (w_drc[DRC1_IDX] && (r_drc1_cnt != 16'hFFFF)) begin
                r_drc1_cnt <= r_drc1_cnt + 16'd1;
            end
        end else if (alloc_ready) begin
            r_alloc_valid <= 1'b0;
        end
    end

    assign rqst_ready    = !w_full;
    assign alloc_valid   = r_alloc_valid;
    assign alloc_seq_sel = r_alloc.seq_sel;
    assign alloc_seq_num = r_alloc.seq_num;
    assign alloc_mask    = r_alloc.mask;
    assign drc_flag      = r_alloc.drc;
    assign occupancy     = r_count;
    assign drc1_cnt      = r_drc1_cnt;

endmodule

// File: tb/tb_memshare_rqst_profiler.sv
// Randomized bench for memshare_rqst_profiler against a queue-based
// reference model plus directed request-pattern scenarios.
module tb_memshare_rqst_profiler;
    import memShare_config_pkg::*;

    localparam int             G   = 5;
    localparam int             W   = 2;
    localparam int             D   = 4;
    localparam logic [G-1:0]   CFG = 5'b10101;

    logic           sys_clk = 1'b0;
    logic           rst;
    logic           rqst_valid;
    logic           rqst_ready;
    logic [G-1:0]   rqst_mask;
    logic [G*W-1:0] rqst_addr;
    logic           alloc_valid;
    logic           alloc_ready;
    logic [G-1:0]   alloc_seq_sel;
    logic           alloc_seq_num;
    logic [G-1:0]   alloc_mask;
    logic [2:0]     drc_flag;
    logic [2:0]     occupancy;
    logic [15:0]    drc1_cnt;

    always #5 sys_clk = ~sys_clk;

    memshare_rqst_profiler dut (
        .sys_clk       (sys_clk),
        .rst           (rst),
        .rqst_valid    (rqst_valid),
        .rqst_ready    (rqst_ready),
        .rqst_mask     (rqst_mask),
        .rqst_addr     (rqst_addr),
        .alloc_valid   (alloc_valid),
        .alloc_ready   (alloc_ready),
        .alloc_seq_sel (alloc_seq_sel),
        .alloc_seq_num (alloc_seq_num),
        .alloc_mask    (alloc_mask),
        .drc_flag      (drc_flag),
        .occupancy     (occupancy),
        .drc1_cnt      (drc1_cnt)
    );

    typedef struct {
        logic [G-1:0]   m;
        logic [G*W-1:0] a;
    } pat_t;

    pat_t         q[$];
    bit           m_valid;
    logic [G-1:0] m_sel;
    logic         m_num;
    logic [G-1:0] m_mask;
    logic [2:0]   m_drc;
    int           m_cnt;
    int           n_checks;
    int           n_fail;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // A requestor lands in seq1 iff some earlier active requestor used the same address.
    function automatic void ref_split(input logic [G-1:0] m, input logic [G*W-1:0] a,
                                      output logic [G-1:0] sel, output logic num,
                                      output logic [2:0] drc);
        int tot[4];
        int shr[4];
        int v;
        sel = '0;
        drc = '0;
        for (int k = 0; k < 4; k++) begin
            tot[k] = 0;
            shr[k] = 0;
        end
        for (int i = 0; i < G; i++) begin
            if (m[i]) begin
                v = int'(a[i*W +: 2]);
                if (tot[v] > 0) sel[i] = 1'b1;
                tot[v]++;
                if (CFG[i]) shr[v]++;
                else if (v % 2 == 1) drc[1] = 1'b1;
            end
        end
        for (int k = 0; k < 4; k++) begin
            if (shr[k] >= 2) drc[0] = 1'b1;
            if (tot[k] > MAX_ALLOC_SEQ_NUM) drc[2] = 1'b1;
        end
        num = |sel;
    endfunction

    task automatic check_all();
        chk("rqst_ready", 32'(rqst_ready), 32'(q.size() < D));
        chk("alloc_valid", 32'(alloc_valid), 32'(m_valid));
        chk("occupancy", 32'(occupancy), 32'(q.size()));
        chk("drc1_cnt", 32'(drc1_cnt), 32'(m_cnt));
        chk("seq_sel", 32'(alloc_seq_sel), 32'(m_sel));
        chk("seq_num", 32'(alloc_seq_num), 32'(m_num));
        chk("alloc_mask", 32'(alloc_mask), 32'(m_mask));
        chk("drc_flag", 32'(drc_flag), 32'(m_drc));
    endtask

    task automatic step();
        bit   push;
        bit   pop;
        pat_t p;
        push = rqst_valid && (q.size() < D);
        pop  = (q.size() > 0) && (!m_valid || alloc_ready);
        if (rst) begin
            q.delete();
            m_valid = 1'b0;
            m_sel   = '0;
            m_num   = 1'b0;
            m_mask  = '0;
            m_drc   = '0;
            m_cnt   = 0;
        end else begin
            if (pop) begin
                p = q.pop_front();
                ref_split(p.m, p.a, m_sel, m_num, m_drc);
                m_mask  = p.m;
                m_valid = 1'b1;
                if (m_drc[0] && m_cnt < 65535) m_cnt++;
            end else if (alloc_ready) begin
                m_valid = 1'b0;
            end
            if (push) q.push_back('{rqst_mask, rqst_addr});
        end
        @(posedge sys_clk);
        #1;
        check_all();
    endtask

    task automatic send_one(input logic [G-1:0] m, input logic [G*W-1:0] a);
        alloc_ready = 1'b1;
        rqst_valid  = 1'b1;
        rqst_mask   = m;
        rqst_addr   = a;
        step();
        rqst_valid  = 1'b0;
        step();
    endtask

    task automatic rand_pat();
        rqst_mask = G'($urandom());
        rqst_addr = (G*W)'($urandom());
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst         = 1'b1;
        rqst_valid  = 1'b0;
        rqst_mask   = '0;
        rqst_addr   = '0;
        alloc_ready = 1'b0;
        step();
        chk("rst_ready", 32'(rqst_ready), 32'd1);
        chk("rst_valid", 32'(alloc_valid), 32'd0);
        rst = 1'b0;
        step();

        send_one(5'b11111, {2'd0, 2'd3, 2'd1, 2'd2, 2'd0});
        chk("a_valid", 32'(alloc_valid), 32'd1);
        chk("a_sel", 32'(alloc_seq_sel), 32'h10);
        chk("a_num", 32'(alloc_seq_num), 32'd1);
        chk("a_drc1", 32'(drc_flag[0]), 32'd1);
        chk("a_cnt", 32'(drc1_cnt), 32'd1);
        step();

        send_one(5'b10111, {2'd3, 2'd0, 2'd2, 2'd1, 2'd0});
        chk("b_drc", 32'(drc_flag), 32'b010);
        chk("b_num", 32'(alloc_seq_num), 32'd0);
        step();

        send_one(5'b11111, {2'd1, 2'd0, 2'd2, 2'd2, 2'd2});
        chk("c_sel", 32'(alloc_seq_sel), 32'b00110);
        chk("c_drc", 32'(drc_flag), 32'b101);
        step();

        alloc_ready = 1'b0;
        rqst_valid  = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            rand_pat();
            step();
            if (i == 4) chk("bp_occ4", 32'(occupancy), 32'd3);
            if (i == 5) begin
                chk("bp_occ5", 32'(occupancy), 32'd4);
                chk("bp_ready5", 32'(rqst_ready), 32'd0);
            end
        end
        rqst_valid  = 1'b0;
        alloc_ready = 1'b1;
        for (int i = 0; i < 8; i++) step();

        rqst_valid = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            rand_pat();
            step();
            if (i >= 2) chk("b2b_valid", 32'(alloc_valid), 32'd1);
        end
        rst = 1'b1;
        step();
        chk("mid_rst_valid", 32'(alloc_valid), 32'd0);
        chk("mid_rst_occ", 32'(occupancy), 32'd0);
        chk("mid_rst_cnt", 32'(drc1_cnt), 32'd0);
        rst        = 1'b0;
        rqst_valid = 1'b0;
        step();

        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(249, 0) == 0);
            rqst_valid  = ($urandom_range(3, 0) != 0);
            alloc_ready = ($urandom_range(3, 0) != 0);
            rand_pat();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
